// File: rtl/flash_boot_loader.sv
// Boot loader: accepts a length-prefixed, checksummed word frame from a host and
// programs it into FLASH, holding the CPU until a frame verifies cleanly.
module flash_boot_loader #(
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 256,
  parameter int TIMEOUT   = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_host_data,
  input  logic              i_host_valid,
  output logic              o_host_ready,
  output logic [DATA_W-1:0] o_flash_addr,
  output logic [DATA_W-1:0] o_flash_in,
  output logic              o_flash_wr,
  output logic              o_cpu_run,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [1:0]        o_err_code
);

  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DATA_W:0] LEN_MAX = (DATA_W+1)'(MAX_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_LOAD, ST_CHK, ST_DONE, ST_ERR
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_last;
  logic [DATA_W-1:0] r_csum;
  logic [CNT_W-1:0]  r_to_cnt;
  logic              r_host_ready;
  logic [DATA_W-1:0] r_flash_addr;
  logic [DATA_W-1:0] r_flash_in;
  logic              r_flash_wr;
  logic              r_cpu_run;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [1:0]        r_err_code;

  logic       w_accept;
  logic       w_in_busy;
  logic       w_len_ok;
  logic       w_timeout;
  logic       w_err_set;
  logic [1:0] w_err_val;

  assign w_accept  = i_host_valid && r_host_ready;
  assign w_in_busy = (r_state == ST_HDR) || (r_state == ST_LOAD) || (r_state == ST_CHK);
  assign w_len_ok  = (i_host_data != '0) && ({1'b0, i_host_data} <= LEN_MAX);
  // An accept on the expiry edge takes priority over the abort.
  assign w_timeout = (TIMEOUT != 0) && w_in_busy && !w_accept &&
                     (r_to_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_err_set = 1'b0;
    w_err_val = 2'd0;
    if (r_state == ST_HDR && w_accept && !w_len_ok) begin
      w_err_set = 1'b1;
      w_err_val = 2'd1;
    end else if (r_state == ST_CHK && w_accept && (i_host_data != r_csum)) begin
      w_err_set = 1'b1;
      w_err_val = 2'd2;
    end else if (w_timeout) begin
      w_err_set = 1'b1;
      w_err_val = 2'd3;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_last       <= '0;
      r_csum       <= '0;
      r_to_cnt     <= '0;
      r_host_ready <= 1'b0;
      r_flash_addr <= '0;
      r_flash_in   <= '0;
      r_flash_wr   <= 1'b0;
      r_cpu_run    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= 2'd0;
    end else begin
      r_flash_wr <= 1'b0;

      if (w_in_busy) begin
        if (w_accept) r_to_cnt <= '0;
        else          r_to_cnt <= r_to_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (i_start) begin
            r_state      <= ST_HDR;
            r_host_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= 2'd0;
            r_cpu_run    <= 1'b0;
            r_to_cnt     <= '0;
          end
        end
        ST_HDR: begin
          if (w_accept && w_len_ok) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
            r_csum  <= '0;
            r_last  <= IDX_W'(i_host_data - 1'b1);
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_flash_wr   <= 1'b1;
            r_flash_addr <= DATA_W'(r_idx);
            r_flash_in   <= i_host_data;
            r_idx        <= r_idx + 1'b1;
            r_csum       <= r_csum + i_host_data;
            if (r_idx == r_last) r_state <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (w_accept && (i_host_data == r_csum)) begin
            r_state      <= ST_DONE;
            r_host_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_cpu_run    <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Any failure overrides the normal transition chosen above.
      if (w_err_set) begin
        r_state      <= ST_ERR;
        r_host_ready <= 1'b0;
        r_busy       <= 1'b0;
        r_done       <= 1'b0;
        r_cpu_run    <= 1'b0;
        r_error      <= 1'b1;
        r_err_code   <= w_err_val;
      end
    end
  end

  assign o_host_ready = r_host_ready;
  assign o_flash_addr = r_flash_addr;
  assign o_flash_in   = r_flash_in;
  assign o_flash_wr   = r_flash_wr;
  assign o_cpu_run    = r_cpu_run;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench for flash_boot_loader: frames, length/checksum/timeout errors, resets.
module tb_flash_boot_loader;

  localparam int DW = 16;
  localparam int MW = 256;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [DW-1:0] i_host_data;
  logic          i_host_valid;
  logic          o_host_ready;
  logic [DW-1:0] o_flash_addr;
  logic [DW-1:0] o_flash_in;
  logic          o_flash_wr;
  logic          o_cpu_run;
  logic          o_busy;
  logic          o_done;
  logic          o_error;
  logic [1:0]    o_err_code;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } wr_t;
  wr_t wr_q[$];

  flash_boot_loader #(.DATA_W(DW), .MAX_WORDS(MW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .i_host_data(i_host_data), .i_host_valid(i_host_valid),
    .o_host_ready(o_host_ready), .o_flash_addr(o_flash_addr),
    .o_flash_in(o_flash_in), .o_flash_wr(o_flash_wr), .o_cpu_run(o_cpu_run),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (o_flash_wr) wr_q.push_back('{a: o_flash_addr, d: o_flash_in, c: cyc});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Present a word and wait (bounded) for the edge that accepts it.
  task automatic send_word(input logic [DW-1:0] w);
    bit ok;
    ok = 1'b0;
    i_host_valid = 1'b1;
    i_host_data  = w;
    for (int k = 0; k < 100; k++) begin
      if (o_host_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("handshake_wait", 32'd0, 32'd1);
  endtask

  task automatic idle_valid();
    i_host_valid = 1'b0;
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [DW-1:0] a,
                          input logic [DW-1:0] d);
    if (idx < wr_q.size()) begin
      check({tag, "_addr"}, 32'(wr_q[idx].a), 32'(a));
      check({tag, "_data"}, 32'(wr_q[idx].d), 32'(d));
    end else begin
      check({tag, "_present"}, 32'(wr_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_status(input string tag, input logic busy, input logic done,
                              input logic err, input logic [1:0] code, input logic run);
    check({tag, "_busy"}, 32'(o_busy), 32'(busy));
    check({tag, "_done"}, 32'(o_done), 32'(done));
    check({tag, "_error"}, 32'(o_error), 32'(err));
    check({tag, "_code"}, 32'(o_err_code), 32'(code));
    check({tag, "_cpu_run"}, 32'(o_cpu_run), 32'(run));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(o_host_ready), 32'd0);
    check({tag, "_wr"}, 32'(o_flash_wr), 32'd0);
    check({tag, "_addr"}, 32'(o_flash_addr), 32'd0);
    check({tag, "_in"}, 32'(o_flash_in), 32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_host_data  = '0;
    i_host_valid = 1'b0;

    // 1. Reset behaviour
    #23;
    check_all_zero("rst_init");
    rst_n = 1'b1;
    repeat (3) tick();
    check_all_zero("idle_after_rst");
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid_idle");
    #2 rst_n = 1'b1;
    tick();
    pulse_start();
    send_word(16'd3);
    send_word(16'h1111);
    check("rst_load_wr_before", 32'(o_flash_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid_load");
    #2 rst_n = 1'b1;
    idle_valid();
    tick();
    i_host_valid = 1'b1;
    tick();
    check("idle_ready_low", 32'(o_host_ready), 32'd0);
    check("idle_busy_low", 32'(o_busy), 32'd0);
    idle_valid();
    tick();
    wr_q.delete();

    // 2. Good frame, back-to-back
    pulse_start();
    check("hdr_ready", 32'(o_host_ready), 32'd1);
    check("hdr_busy", 32'(o_busy), 32'd1);
    send_word(16'd3);
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    check("chk_ready", 32'(o_host_ready), 32'd1);
    send_word(16'h6666);
    idle_valid();
    check_status("good", 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    check("good_ready", 32'(o_host_ready), 32'd0);
    check("good_nwr", 32'(wr_q.size()), 32'd3);
    check_wr("good_w0", 0, 16'd0, 16'h1111);
    check_wr("good_w1", 1, 16'd1, 16'h2222);
    check_wr("good_w2", 2, 16'd2, 16'h3333);
    if (wr_q.size() == 3) check("good_consec", 32'(wr_q[2].c - wr_q[0].c), 32'd2);
    tick();
    check("addr_hold", 32'(o_flash_addr), 32'd2);
    check("data_hold", 32'(o_flash_in), 32'h3333);
    check("wr_low_after", 32'(o_flash_wr), 32'd0);
    wr_q.delete();

    // 3. Bad checksum, then recovery
    pulse_start();
    check_status("restart_clear", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    send_word(16'd3);
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    send_word(16'h6667);
    idle_valid();
    check_status("badsum", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    check("badsum_nwr", 32'(wr_q.size()), 32'd3);
    tick();
    pulse_start();
    check_status("err_restart", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    send_word(16'd1);
    send_word(16'hABCD);
    send_word(16'hABCD);
    idle_valid();
    check_status("recover", 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    wr_q.delete();

    // 4. Bad lengths
    pulse_start();
    send_word(16'd0);
    idle_valid();
    check_status("len0", 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    tick();
    pulse_start();
    send_word(16'd257);
    idle_valid();
    check_status("len257", 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    repeat (3) tick();
    check("len_nwr", 32'(wr_q.size()), 32'd0);
    pulse_start();
    send_word(16'd256);
    idle_valid();
    check("len256_busy", 32'(o_busy), 32'd1);
    check("len256_error", 32'(o_error), 32'd0);
    // Let this frame time out to get back to a known state.
    repeat (TO) tick();
    check_status("len256_to", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    wr_q.delete();

    // 5. Timeout exact cycle, then accept on the final cycle
    pulse_start();
    send_word(16'd4);
    send_word(16'h0001);
    send_word(16'h0002);
    idle_valid();
    repeat (TO - 1) tick();
    check_status("to_before", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    check_status("to_hit", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    check("to_nwr", 32'(wr_q.size()), 32'd2);
    wr_q.delete();
    pulse_start();
    send_word(16'd4);
    send_word(16'h0001);
    send_word(16'h0002);
    idle_valid();
    repeat (TO - 1) tick();
    send_word(16'h0003);
    idle_valid();
    check_status("to_race", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    send_word(16'h0004);
    send_word(16'h000A);
    idle_valid();
    check_status("to_race_done", 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    check_wr("to_race_w3", 3, 16'd3, 16'h0004);
    wr_q.delete();

    // 6. Checksum wrap with START ignored mid-load
    pulse_start();
    send_word(16'd2);
    send_word(16'hFFFF);
    i_start = 1'b1;
    send_word(16'h0002);
    i_start = 1'b0;
    check("start_ignored_busy", 32'(o_busy), 32'd1);
    send_word(16'h0001);
    idle_valid();
    check_status("wrap", 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    check_wr("wrap_w0", 0, 16'd0, 16'hFFFF);
    check_wr("wrap_w1", 1, 16'd1, 16'h0002);
    check("wrap_nwr", 32'(wr_q.size()), 32'd2);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
